uart_byte_receiver: RTL and testbench

// - 8N1 UART receiver for the host-PC -> FPGA link; the reverse direction of the existing uart_tx path.
// - Deserialises the raw RX pin and buffers bytes in a FIFO.
// - Delivers bytes to GPU-side consumers (command/scene loaders) over a valid/ready port.
// - Runs in one clock domain; clk is typically the 50 MHz divider output.

---
 rtl/uart_byte_receiver_pkg.sv | 19 +
 rtl/uart_byte_receiver_sync_byte_fifo.sv | 62 ++++++
 rtl/uart_byte_receiver.sv | 157 +++++++++++++++
 tb/tb_uart_byte_receiver.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_byte_receiver_pkg.sv
// Shared types and constants for the UART byte receiver and its FIFO.
package uart_byte_receiver_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } uart_rx_state_e;

    // Width of a counter that must reach 2*clk_div-1.
    function automatic int baud_cnt_width(input int clk_div);
        return (clk_div < 1) ? 1 : $clog2(2 * clk_div);
    endfunction

endpackage

// File: rtl/uart_byte_receiver_sync_byte_fifo.sv
// Single-clock first-word-fall-through byte FIFO; depth 2**ASIZE.
module sync_byte_fifo
    import uart_byte_receiver_pkg::*;
#(
    parameter int ASIZE = 4,
    parameter int WIDTH = UART_DATA_BITS
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [ASIZE:0]   level
);

    localparam int DEPTH = 1 << ASIZE;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [ASIZE:0]   wr_cnt_q, wr_cnt_d;
    logic [ASIZE:0]   rd_cnt_q, rd_cnt_d;
    logic             push_ok;
    logic             pop_ok;

    // Counters carry one extra bit so full and empty are distinguishable.
    assign level   = wr_cnt_q - rd_cnt_q;
    assign empty   = (level == '0);
    assign full    = (level == (ASIZE + 1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = empty ? '0 : mem_q[rd_cnt_q[ASIZE-1:0]];

    // Next-state for the read/write counters.
    always_comb begin
        wr_cnt_d = wr_cnt_q + (ASIZE + 1)'(push_ok);
        rd_cnt_d = rd_cnt_q + (ASIZE + 1)'(pop_ok);
    end

    // Counter registers.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    // Storage write.
    // NOTE: the array has no reset; contents are only visible through valid counters.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_cnt_q[ASIZE-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver: synchroniser, mid-bit sampling FSM, byte FIFO on a valid/ready port.
module uart_byte_receiver
    import uart_byte_receiver_pkg::*;
#(
    parameter int UART_CLK_DIV = 434,
    parameter int FIFO_ASIZE   = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      uart_rx,
    output logic [UART_DATA_BITS-1:0] rdata,
    output logic                      rvalid,
    input  logic                      rready,
    output logic [FIFO_ASIZE:0]       level,
    output logic                      frame_err,
    output logic                      overflow,
    input  logic                      clr_overflow
);

    localparam int               CNT_W     = baud_cnt_width(UART_CLK_DIV);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(UART_CLK_DIV - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(2 * UART_CLK_DIV - 1);
    localparam logic [2:0]       LAST_IDX  = 3'(UART_DATA_BITS - 1);

    logic                      rx_meta_q, rx_s_q;
    uart_rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [2:0]                idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      frame_err_q, frame_err_d;
    logic                      overflow_q, overflow_d;
    logic                      push;
    logic                      pop;
    logic                      drop;
    logic                      fifo_full;
    logic                      fifo_empty;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Receive FSM next-state: counter reloads to zero on every state entry.
    // NOTE: every output gets a default first so no path leaves a latch behind.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        idx_d       = idx_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        idx_d   = '0;
                    end
                end
            end
            DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s_q;
                    if (idx_q == LAST_IDX) state_d = STOP;
                    else                   idx_d   = idx_q + 3'd1;
                end
            end
            STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s_q) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // FSM, counter, shift register and frame-error pulse registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign pop  = rready && !fifo_empty;
    assign drop = push && fifo_full && !pop;

    // Sticky overflow: a drop wins over a simultaneous clear.
    always_comb begin
        overflow_d = overflow_q;
        if (drop)              overflow_d = 1'b1;
        else if (clr_overflow) overflow_d = 1'b0;
    end

    // Overflow flag register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) overflow_q <= 1'b0;
        else         overflow_q <= overflow_d;
    end

    sync_byte_fifo #(
        .ASIZE (FIFO_ASIZE),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .wdata  (shift_q),
        .pop    (pop),
        .rdata  (rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (level)
    );

    assign rvalid    = !fifo_empty;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Scoreboard bench for uart_byte_receiver: 8-cycle bits, 4-deep FIFO.
module tb_uart_byte_receiver;

    localparam int DIV   = 4;
    localparam int ASIZE = 2;
    localparam int BIT   = 2 * DIV;
    localparam int DEPTH = 1 << ASIZE;

    logic             clk = 1'b0;
    logic             resetn = 1'b1;
    logic             uart_rx = 1'b1;
    logic [7:0]       rdata;
    logic             rvalid;
    logic             rready = 1'b0;
    logic [ASIZE:0]   level;
    logic             frame_err;
    logic             overflow;
    logic             clr_overflow = 1'b0;

    int               n_checks = 0;
    int               n_pass   = 0;
    int               ferr_seen = 0;
    int               exp_ferr  = 0;
    bit               exp_overflow = 1'b0;
    bit               rand_rready  = 1'b0;
    logic [7:0]       exp_q [$];

    uart_byte_receiver #(
        .UART_CLK_DIV (DIV),
        .FIFO_ASIZE   (ASIZE)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .uart_rx      (uart_rx),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .rready       (rready),
        .level        (level),
        .frame_err    (frame_err),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else             n_pass++;
    endtask

    // Monitor: every accepted byte is compared with the head of the model queue.
    always @(negedge clk) begin
        if (resetn && rvalid && rready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL pop_unexpected: got byte %02h, model queue empty (t=%0t)", rdata, $time);
            end else begin
                check("pop_data", 32'(rdata), 32'(exp_q.pop_front()));
            end
        end
        if (resetn && frame_err) ferr_seen++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_rready) rready = 1'($urandom_range(0, 1));
        end
    endtask

    // Reference behaviour: a good stop bit delivers the byte unless the FIFO is
    // full with no pop in that cycle; a low stop bit is one framing error.
    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit pulse_pop);
        uart_rx = 1'b0;
        tick(BIT);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(BIT);
        end
        check("level_at_stop", 32'(level), 32'(exp_q.size()));
        if (stop_ok) begin
            if (exp_q.size() < DEPTH || pulse_pop) exp_q.push_back(b);
            else                                   exp_overflow = 1'b1;
        end else begin
            exp_ferr++;
        end
        uart_rx = stop_ok;
        if (pulse_pop) begin
            // Line sample at mid-stop lands on the 7th edge of the stop bit.
            tick(BIT - 2);
            rready = 1'b1;
            tick(1);
            rready = 1'b0;
            tick(1);
        end else begin
            tick(BIT);
        end
        uart_rx = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        rand_rready = 1'b0;
        rready = 1'b1;
        while ((exp_q.size() != 0 || rvalid) && n < 300) begin
            tick(1);
            n++;
        end
        rready = 1'b0;
        check("drain_done", 32'(exp_q.size() == 0 && !rvalid), 32'd1);
        check("drain_level", 32'(level), 32'd0);
        check("ferr_count", 32'(ferr_seen), 32'(exp_ferr));
    endtask

    initial begin
        // Reset state
        #2 resetn = 1'b0;
        tick(3);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        resetn = 1'b1;
        tick(4);

        // Single byte, held in the FIFO
        send_byte(8'hA5, 1'b1, 1'b0);
        check("single_rvalid", 32'(rvalid), 32'd1);
        check("single_rdata", 32'(rdata), 32'hA5);
        check("single_level", 32'(level), 32'd1);
        rready = 1'b1;
        tick(1);
        rready = 1'b0;
        check("single_pop_level", 32'(level), 32'd0);
        check("single_pop_rvalid", 32'(rvalid), 32'd0);

        // Short low glitch must not start a frame
        uart_rx = 1'b0;
        tick(3);
        uart_rx = 1'b1;
        tick(20);
        check("glitch_level", 32'(level), 32'd0);
        check("glitch_ferr", 32'(ferr_seen), 32'(exp_ferr));
        send_byte(8'h3C, 1'b1, 1'b0);
        drain();

        // Framing error with the line held low, then recovery
        send_byte(8'h3C, 1'b0, 1'b0);
        uart_rx = 1'b0;
        tick(40 - BIT);
        uart_rx = 1'b1;
        tick(10);
        check("ferr_pulses", 32'(ferr_seen), 32'(exp_ferr));
        check("ferr_level", 32'(level), 32'd0);
        send_byte(8'h5A, 1'b1, 1'b0);
        drain();

        // Overflow: fifth byte dropped
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1, 1'b0);
        check("ovf_level", 32'(level), 32'(exp_q.size()));
        check("ovf_flag", 32'(overflow), 32'(exp_overflow));
        check("ovf_rdata", 32'(rdata), 32'h01);
        clr_overflow = 1'b1;
        tick(1);
        clr_overflow = 1'b0;
        exp_overflow = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'(exp_overflow));
        drain();

        // Overflow variant: pop coincides with the fifth push
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1, 1'b0);
        send_byte(8'h05, 1'b1, 1'b1);
        check("ovf_var_flag", 32'(overflow), 32'(exp_overflow));
        check("ovf_var_level", 32'(level), 32'(exp_q.size()));
        drain();

        // Back-to-back frames, no idle gap
        rready = 1'b1;
        send_byte(8'h00, 1'b1, 1'b0);
        send_byte(8'hFF, 1'b1, 1'b0);
        drain();

        // Random bytes, random gaps and random consumer backpressure
        for (int batch = 0; batch < 4; batch++) begin
            rand_rready = 1'b1;
            for (int k = 0; k < 3; k++) begin
                tick($urandom_range(0, 5));
                send_byte(8'($urandom_range(0, 255)), 1'b1, 1'b0);
            end
            drain();
        end

        // Reset in the middle of data bit 4 of 0x81, with a byte already queued
        send_byte(8'h11, 1'b1, 1'b0);
        uart_rx = 1'b0;
        tick(BIT);
        for (int i = 0; i < 4; i++) begin
            uart_rx = 1'(8'h81 >> i);
            tick(BIT);
        end
        uart_rx = 1'b0;
        tick(BIT / 2);
        resetn = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_rvalid", 32'(rvalid), 32'd0);
        check("midrst_level", 32'(level), 32'd0);
        check("midrst_rdata", 32'(rdata), 32'd0);
        check("midrst_frame_err", 32'(frame_err), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        uart_rx = 1'b1;
        tick(3);
        resetn = 1'b1;
        tick(4);
        send_byte(8'h7E, 1'b1, 1'b0);
        check("post_rst_rdata", 32'(rdata), 32'h7E);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
